// File: rtl/operand_regfile.sv
// Clocked operand register file: two registered read ports with write-first
// bypass, one write-back port, and a per-register busy scoreboard for RAW stalls.
module operand_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Read_en,
  input  logic [ADDR_WIDTH-1:0] Read_register1,
  input  logic [ADDR_WIDTH-1:0] Read_register2,
  output logic [DATA_WIDTH-1:0] Read_data1,
  output logic [DATA_WIDTH-1:0] Read_data2,
  output logic                  Read_valid,
  output logic                  Stall,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Write_register,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  Reserve_en,
  input  logic [ADDR_WIDTH-1:0] Reserve_register,
  output logic [ADDR_WIDTH:0]   Busy_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic                  rvalid_q;
  logic                  wr_ok, hit1, hit2, accept;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Handshake: a read request (Read_en) is accepted in the cycle it is
  // presented when Stall is low; its operands appear with Read_valid exactly
  // one cycle later. A stalled request is simply dropped and must be re-presented.
  assign wr_ok  = RegWrite && !is_zero(Write_register);
  assign hit1   = wr_ok && (Write_register == Read_register1);
  assign hit2   = wr_ok && (Write_register == Read_register2);
  assign Stall  = Read_en && ((busy_q[Read_register1] && !hit1) ||
                              (busy_q[Read_register2] && !hit2));
  assign accept = Read_en && !Stall;

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (!is_zero(Read_register1))
      rd1_d = hit1 ? Write_data : regs_q[Read_register1];
    if (!is_zero(Read_register2))
      rd2_d = hit2 ? Write_data : regs_q[Read_register2];
  end

  // Clear then set, so a same-cycle reservation supersedes the retiring producer.
  always_comb begin
    busy_d = busy_q;
    if (RegWrite)
      busy_d[Write_register] = 1'b0;
    if (Reserve_en && !is_zero(Reserve_register))
      busy_d[Reserve_register] = 1'b1;
  end

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++)
      busy_count_d = busy_count_d + (ADDR_WIDTH+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      if (wr_ok)
        regs_q[Write_register] <= Write_data;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      rvalid_q     <= accept;
      if (accept) begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end
  end

  assign Read_data1 = rd1_q;
  assign Read_data2 = rd2_q;
  assign Read_valid = rvalid_q;
  assign Busy_count = busy_count_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Bench for operand_regfile: directed scenarios plus randomized traffic, with a
// reference model feeding an expected queue that a negedge monitor drains.
module tb_operand_regfile;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int EW    = 32 + 2*DW;

  logic          clk, reset;
  logic          Read_en, RegWrite, Reserve_en;
  logic [AW-1:0] Read_register1, Read_register2, Write_register, Reserve_register;
  logic [DW-1:0] Write_data, Read_data1, Read_data2;
  logic          Read_valid, Stall;
  logic [AW:0]   Busy_count;

  operand_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .Read_en(Read_en), .Read_register1(Read_register1), .Read_register2(Read_register2),
    .Read_data1(Read_data1), .Read_data2(Read_data2), .Read_valid(Read_valid),
    .Stall(Stall), .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .Reserve_en(Reserve_en), .Reserve_register(Reserve_register),
    .Busy_count(Busy_count)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] hold1, hold2;
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] mon_e;
  logic          mon_v;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    hold1 = '0;
    hold2 = '0;
    exp_q.delete();
  endtask

  // Monitor: every cycle outside reset, Read_valid must match whether an
  // accepted read is due now, and the data must match the newest accepted result.
  always @(negedge clk) begin
    if (!reset) begin
      mon_v = 1'b0;
      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        mon_v = (mon_e[EW-1:2*DW] == 32'(cyc));
      end
      check("read_valid", Read_valid, mon_v);
      if (mon_v) begin
        void'(exp_q.pop_front());
        hold1 = mon_e[2*DW-1:DW];
        hold2 = mon_e[DW-1:0];
      end
      check("read_data1", Read_data1, hold1);
      check("read_data2", Read_data2, hold2);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic ren, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rsv, input logic [AW-1:0] ra);
    logic          h1, h2, st;
    logic [DW-1:0] e1, e2;
    int            n;
    @(negedge clk);
    Read_en = ren; Read_register1 = r1; Read_register2 = r2;
    RegWrite = we; Write_register = wa; Write_data = wd;
    Reserve_en = rsv; Reserve_register = ra;
    #1;
    h1 = we && (wa == r1) && (wa != 0);
    h2 = we && (wa == r2) && (wa != 0);
    e1 = (r1 == 0) ? '0 : (h1 ? wd : m_mem[r1]);
    e2 = (r2 == 0) ? '0 : (h2 ? wd : m_mem[r2]);
    st = ren && ((m_busy[r1] && !h1) || (m_busy[r2] && !h2));
    check("stall", Stall, st);
    if (ren && !st) exp_q.push_back({32'(cyc + 1), e1, e2});
    if (we && wa != 0) m_mem[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (rsv && ra != 0) m_busy[ra] = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    check("busy_count", Busy_count, n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd1"}, Read_data1, 0);
    check({tag, "_rd2"}, Read_data2, 0);
    check({tag, "_valid"}, Read_valid, 0);
    check({tag, "_busy_count"}, Busy_count, 0);
    check({tag, "_stall"}, Stall, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    Read_en = 0; Read_register1 = 0; Read_register2 = 0;
    RegWrite = 0; Write_register = 0; Write_data = 0;
    Reserve_en = 0; Reserve_register = 0;
    model_clear();
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    #2 reset = 1'b0;

    // basic write then read
    drive(0, 0, 0, 1, 3, 32'd3, 0, 0);
    drive(0, 0, 0, 1, 25, 32'd15, 0, 0);
    drive(1, 3, 25, 0, 0, 0, 0, 0);
    // write-first bypass on both ports
    drive(1, 25, 25, 1, 25, 32'hDEADBEEF, 0, 0);
    idle(1);
    // register 0: write ignored, reserve ignored, bypass yields 0
    drive(0, 0, 0, 1, 0, 32'h55, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 32'h55, 0, 0);
    // RAW stall, held outputs, then released by write-back bypass
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    drive(1, 7, 3, 0, 0, 0, 0, 0);
    drive(1, 7, 3, 1, 7, 32'h11, 0, 0);
    idle(1);
    // reserve and write same register: reservation wins
    drive(0, 0, 0, 1, 9, 32'h99, 1, 9);
    idle(1);
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 9, 32'h9A, 0, 0);
    // async reset mid-cycle with 3 busy and a valid read
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    drive(1, 25, 3, 0, 0, 0, 1, 4);
    check("pre_reset_valid", Read_valid, 1);
    check("pre_reset_busy", Busy_count, 3);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    Read_en = 0; RegWrite = 0; Reserve_en = 0;
    model_clear();
    @(posedge clk);
    #2 reset = 1'b0;
    drive(1, 25, 25, 0, 0, 0, 0, 0);
    idle(1);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] r1, r2, wa, ra;
      r1 = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
      r2 = AW'($urandom_range(0, 7));
      wa = AW'($urandom_range(0, 7));
      ra = AW'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, r1, r2, $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 3) == 0, ra);
    end

    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Parametrised, clocked successor to the processor's combinational operand-preparation register file.
- Holds 2**ADDR_WIDTH general registers of DATA_WIDTH bits.
- Provides two source-operand read ports with a one-cycle registered output and a write-first bypass, plus one write-back port.
- Adds a per-register busy scoreboard so the issue stage can stall on RAW hazards against in-flight destinations.

Parameters:
- DATA_WIDTH, 32, register and data width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and can never be marked busy.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Read_en  input  1  operand read request for this cycle.
- Read_register1  input  ADDR_WIDTH  source register index, port 1.
- Read_register2  input  ADDR_WIDTH  source register index, port 2.
- Read_data1  output  DATA_WIDTH  registered operand 1.
- Read_data2  output  DATA_WIDTH  registered operand 2.
- Read_valid  output  1  Read_data1/2 hold an accepted read's result this cycle.
- Stall  output  1  combinational: the current read request is refused.
- RegWrite  input  1  write-back enable.
- Write_register  input  ADDR_WIDTH  write-back destination index.
- Write_data  input  DATA_WIDTH  write-back value.
- Reserve_en  input  1  issue stage marks a destination as pending.
- Reserve_register  input  ADDR_WIDTH  destination index to mark busy.
- Busy_count  output  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - All registers = 0 and all busy bits = 0.
  - Read_data1 = Read_data2 = 0, Read_valid = 0, Busy_count = 0.
  - Stall is combinational and follows its inputs.
- Write:
  - At a rising edge with RegWrite=1, Register[Write_register] <= Write_data.
  - Suppressed when ZERO_REG=1 and Write_register=0.
- Hit (per source port): RegWrite=1 and Write_register equals that port's index, excluding register 0 when ZERO_REG=1.
- Stall (combinational): Read_en=1 and, for either port, the source register is busy and that port does not hit.
- Read acceptance: a read is accepted when Read_en=1 and Stall=0.
- Read result (accepted in cycle N):
  - At the edge ending cycle N, each Read_dataK <= Write_data if that port hits, else Register[Read_registerK]. This is write-first bypass.
  - Read_valid = 1 during cycle N+1. Latency is exactly one cycle.
- No accepted read in cycle N (Read_en=0 or Stall=1):
  - Read_valid = 0 in cycle N+1.
  - Read_data1/2 hold their previous values; they are not cleared.
- Register 0 with ZERO_REG=1: always reads 0, including through the bypass path.
- Scoreboard, at each rising edge:
  - RegWrite clears busy[Write_register].
  - Reserve_en sets busy[Reserve_register].
  - If both act on the same index, set wins: the new producer supersedes the old one.
  - Reserve of register 0 is ignored when ZERO_REG=1.
  - Reserving an already-busy register leaves it busy.
  - Writing a non-busy register leaves it clear.
- Busy_count: registered popcount of the busy bits, updated on the same edge as the busy bits. Range is 0 to 2**ADDR_WIDTH (2**ADDR_WIDTH-1 when ZERO_REG=1).
- Same cycle, read and reserve of the same register: the read uses the pre-reserve busy state. It is not stalled by its own reservation.
- Both ports may name the same register; each port resolves independently with identical results.

Test Plan:
- Reset, then write R3=3 and R25=15 in two cycles; read (3,25) -> next cycle Read_data1=3, Read_data2=15, Read_valid=1.
- Read (25,25) with RegWrite=1, Write_register=25, Write_data=0xDEADBEEF in the same cycle -> both outputs 0xDEADBEEF one cycle later.
- ZERO_REG=1: write R0=0x55, reserve R0, read (0,0) -> outputs 0, Stall=0, Busy_count=0.
- Reserve R7, then read (7,3) -> Stall=1 and Read_valid=0 next cycle with outputs held. Write R7=0x11 while the read is held -> Stall=0 that cycle; next cycle Read_data1=0x11 and Busy_count back to 0.
- Reserve and write R9 in the same cycle -> R9 still busy, Busy_count=1. A read of R9 two cycles later with no write stalls.
- Assert reset asynchronously mid-cycle with 3 registers busy and Read_valid=1 -> all outputs 0 immediately; a read of R25 after release returns 0.
